// File: rtl/blink_sequencer_pkg.sv
// Shared types and default constants for the blink sequencer (package blink_pkg).
// Optional repeat feature is enabled by defining BLINK_SEQ_REPEAT_EN.
package blink_pkg;

  localparam int unsigned DEF_STEPS = 8;
  localparam int unsigned DEF_DUR_W = 4;
  localparam int unsigned DEF_REP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } blink_seq_state_t;

  typedef struct packed {
    logic                 level;
    logic [DEF_DUR_W-1:0] dur;
  } step_t;

endpackage

// File: rtl/blink_sequencer_if.sv
// Control/status bundle between a host and blink_sequencer.
// i_repeat exists only when BLINK_SEQ_REPEAT_EN is defined.
interface blink_sequencer_if
  import blink_pkg::*;
#(
  parameter int unsigned STEPS = DEF_STEPS,
  parameter int unsigned DUR_W = DEF_DUR_W,
  parameter int unsigned REP_W = DEF_REP_W
);

  logic                     i_tick;
  logic                     i_start;
  logic                     i_abort;
  logic                     i_wr_en;
  logic [$clog2(STEPS)-1:0] i_wr_addr;
  logic [DUR_W:0]           i_wr_data;
`ifdef BLINK_SEQ_REPEAT_EN
  logic [REP_W-1:0]         i_repeat;
`endif
  logic                     o_out;
  logic                     o_busy;
  logic                     o_done;
  logic [$clog2(STEPS)-1:0] o_step;

  modport master (
`ifdef BLINK_SEQ_REPEAT_EN
    output i_repeat,
`endif
    output i_tick, i_start, i_abort, i_wr_en, i_wr_addr, i_wr_data,
    input  o_out, o_busy, o_done, o_step
  );

  modport slave (
`ifdef BLINK_SEQ_REPEAT_EN
    input  i_repeat,
`endif
    input  i_tick, i_start, i_abort, i_wr_en, i_wr_addr, i_wr_data,
    output o_out, o_busy, o_done, o_step
  );

endinterface

// File: rtl/blink_step_timer.sv
// Loadable down-counter with tick enable; expire flags the tick that ends a step.
module blink_step_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && (count == W'(1));

endmodule

// File: rtl/blink_sequencer.sv
// Programmable {level, duration} blink sequencer driven by a 1 Hz tick.
// BLINK_SEQ_REPEAT_EN adds i_repeat and a repeat counter (passes = i_repeat+1).
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int unsigned STEPS = DEF_STEPS,
  parameter int unsigned DUR_W = DEF_DUR_W,
  parameter int unsigned REP_W = DEF_REP_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  blink_sequencer_if.slave   bus
);

  localparam int unsigned IW = $clog2(STEPS);

  logic [DUR_W:0]   prog [STEPS];
  blink_seq_state_t state;
  logic [IW-1:0]    index;
  logic             out_r;
  logic             busy_r;
  logic             done_r;
  logic             rep_more;

  logic [DUR_W:0]   cur;
  logic [DUR_W-1:0] cur_dur;
  logic             cur_lvl;
  logic             expire;
  logic             tmr_load;
  logic             tmr_tick;

`ifdef BLINK_SEQ_REPEAT_EN
  logic [REP_W-1:0] rep_cnt;
  assign rep_more = (rep_cnt != '0);
`else
  assign rep_more = 1'b0;
`endif

  assign cur     = prog[index];
  assign cur_dur = cur[DUR_W-1:0];
  assign cur_lvl = cur[DUR_W];

  // Ticks only count in RUN, so a tick landing in LOAD is dropped.
  assign tmr_load = (state == ST_LOAD) && (cur_dur != '0) && !bus.i_abort;
  assign tmr_tick = bus.i_tick && (state == ST_RUN) && !bus.i_abort;

  blink_step_timer #(
    .W (DUR_W)
  ) u_timer (
    .clk      (i_clk),
    .rst      (i_rst),
    .clear    (bus.i_abort),
    .load     (tmr_load),
    .load_val (cur_dur),
    .tick     (tmr_tick),
    .expire   (expire)
  );

  // Writes only while not busy (IDLE or DONE).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < STEPS; i++) begin
        prog[i] <= '0;
      end
    end else if (bus.i_wr_en && !busy_r) begin
      prog[bus.i_wr_addr] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      index  <= '0;
      out_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef BLINK_SEQ_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      if (bus.i_abort) begin
        state  <= ST_IDLE;
        index  <= '0;
        out_r  <= 1'b0;
        busy_r <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            out_r <= 1'b0;
            index <= '0;
            if (bus.i_start) begin
              state  <= ST_LOAD;
              busy_r <= 1'b1;
`ifdef BLINK_SEQ_REPEAT_EN
              rep_cnt <= bus.i_repeat;
`endif
            end
          end
          ST_LOAD: begin
            if (cur_dur == '0) begin
              // End-of-pass on a zero-duration marker.
              if (rep_more) begin
`ifdef BLINK_SEQ_REPEAT_EN
                rep_cnt <= rep_cnt - 1'b1;
`endif
                index <= '0;
                state <= ST_LOAD;
              end else begin
                state  <= ST_DONE;
                done_r <= 1'b1;
                out_r  <= 1'b0;
                busy_r <= 1'b0;
              end
            end else begin
              out_r <= cur_lvl;
              state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (expire) begin
              if (index == IW'(STEPS - 1)) begin
                if (rep_more) begin
`ifdef BLINK_SEQ_REPEAT_EN
                  rep_cnt <= rep_cnt - 1'b1;
`endif
                  index <= '0;
                  state <= ST_LOAD;
                end else begin
                  state  <= ST_DONE;
                  done_r <= 1'b1;
                  out_r  <= 1'b0;
                  busy_r <= 1'b0;
                end
              end else begin
                index <= index + 1'b1;
                state <= ST_LOAD;
              end
            end
          end
          ST_DONE: begin
            index <= '0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_out  = out_r;
  assign bus.o_busy = busy_r;
  assign bus.o_done = done_r;
  assign bus.o_step = index;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer: per-tick scoreboard of {level, step}
// plus done-pulse timing; repeat scenario runs when BLINK_SEQ_REPEAT_EN is defined.
module tb_blink_sequencer;

  localparam int STEPS = 8;
  localparam int DUR_W = 4;
  localparam int REP_W = 4;
  localparam int IW    = 3;

  typedef struct packed {
    logic          lvl;
    logic [IW-1:0] step;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blink_sequencer_if #(.STEPS(STEPS), .DUR_W(DUR_W), .REP_W(REP_W)) bus ();

  blink_sequencer #(.STEPS(STEPS), .DUR_W(DUR_W), .REP_W(REP_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int tcnt;
  int exp_done_lat;
  logic [DUR_W:0] model_prog [STEPS];
  exp_t exp_q [$];

  task automatic drive_idle();
    bus.i_tick    = 1'b0;
    bus.i_start   = 1'b0;
    bus.i_abort   = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_wr_addr = '0;
    bus.i_wr_data = '0;
`ifdef BLINK_SEQ_REPEAT_EN
    bus.i_repeat  = '0;
`endif
  endtask

  task automatic wr(input int addr, input logic [DUR_W:0] data);
    @(posedge clk); #1;
    bus.i_wr_en   = 1'b1;
    bus.i_wr_addr = IW'(addr);
    bus.i_wr_data = data;
    @(posedge clk); #1;
    bus.i_wr_en = 1'b0;
    model_prog[addr] = data;
  endtask

  function automatic void build_expect(input int passes);
    int   total;
    bit   wrapped;
    exp_t e;
    logic [DUR_W-1:0] d;
    total   = 0;
    wrapped = 1'b0;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      wrapped = 1'b1;
      for (int i = 0; i < STEPS; i++) begin
        d = model_prog[i][DUR_W-1:0];
        if (d == '0) begin
          wrapped = 1'b0;
          break;
        end
        for (int k = 0; k < int'(d); k++) begin
          e.lvl  = model_prog[i][DUR_W];
          e.step = IW'(i);
          exp_q.push_back(e);
          total++;
        end
      end
    end
    exp_done_lat = (total == 0) ? 2 : (wrapped ? 1 : 2);
  endfunction

  // Start a program, tick every 4th cycle, score each tick and the done pulse.
  task automatic run(input string name, input int passes, input bit busy_wr,
                     input bit pre_wr, input logic [DUR_W:0] pre_data, input bit chg_rep);
    exp_t e;
    bit   seen;
    int   last;
    if (pre_wr) model_prog[0] = pre_data;
    build_expect(passes);
    last = 0;
    seen = 1'b0;
    tcnt = 1;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_tick  = 1'b0;
    if (pre_wr) begin
      bus.i_wr_en   = 1'b1;
      bus.i_wr_addr = '0;
      bus.i_wr_data = pre_data;
    end
    for (int it = 1; it <= 400 && !seen; it++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_wr_en = 1'b0;
      tcnt++;
      bus.i_tick = ((tcnt % 4) == 0);
      if (busy_wr && it == 5) begin
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = '0;
        bus.i_wr_data = {1'b0, 4'd5};
      end
`ifdef BLINK_SEQ_REPEAT_EN
      if (chg_rep && it == 10) bus.i_repeat = '0;
`endif
      @(negedge clk);
      if (bus.i_tick && bus.o_busy) begin
        checks++;
        last = it;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_tick: iter %0d out=%b step=%0d, required no tick in RUN",
                   name, it, bus.o_out, bus.o_step);
        end else begin
          e = exp_q.pop_front();
          if (bus.o_out !== e.lvl || bus.o_step !== e.step) begin
            errors++;
            $display("FAIL %s tick_out: iter %0d out=%b step=%0d, required out=%b step=%0d",
                     name, it, bus.o_out, bus.o_step, e.lvl, e.step);
          end
        end
      end
      if (bus.o_done === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (it !== last + exp_done_lat) begin
          errors++;
          $display("FAIL %s done_timing: done at iter %0d, required iter %0d",
                   name, it, last + exp_done_lat);
        end
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL %s missing_ticks: %0d expected ticks left, required 0", name, exp_q.size());
        end
        checks++;
        if (bus.o_out !== 1'b0) begin
          errors++;
          $display("FAIL %s done_out: out=%b, required 0", name, bus.o_out);
        end
        @(posedge clk); #1;
        bus.i_tick = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
          errors++;
          $display("FAIL %s done_pulse: done=%b busy=%b after done, required 0 0",
                   name, bus.o_done, bus.o_busy);
        end
      end
    end
    bus.i_tick = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: done=0 within 400 cycles, required done pulse", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < STEPS; i++) model_prog[i] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_out, bus.o_busy, bus.o_done, bus.o_step} !== 6'b0) begin
      errors++;
      $display("FAIL reset_hold: out/busy/done/step=%b, required 000000",
               {bus.o_out, bus.o_busy, bus.o_done, bus.o_step});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_out, bus.o_busy, bus.o_done, bus.o_step} !== 6'b0) begin
      errors++;
      $display("FAIL reset_release: out/busy/done/step=%b, required 000000",
               {bus.o_out, bus.o_busy, bus.o_done, bus.o_step});
    end
  endtask

  task automatic test_program();
    wr(0, {1'b1, 4'd3});
    wr(1, {1'b0, 4'd2});
    wr(2, {1'b1, 4'd1});
    wr(3, {1'b1, 4'd0});
    run("program", 1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < STEPS; i++) wr(i, {((i % 2) == 0) ? 1'b1 : 1'b0, 4'd1});
    run("wrap", 1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_abort();
    bit hit;
    bit done_seen;
    wr(0, {1'b1, 4'd3});
    wr(1, {1'b0, 4'd2});
    wr(2, {1'b1, 4'd1});
    wr(3, {1'b1, 4'd0});
    hit  = 1'b0;
    tcnt = 1;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    for (int it = 1; it <= 100 && !hit; it++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      tcnt++;
      bus.i_tick = ((tcnt % 4) == 0);
      if (bus.i_tick && bus.o_busy && bus.o_step == 3'd1) begin
        bus.i_abort = 1'b1;
        hit = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.i_abort = 1'b0;
    bus.i_tick  = 1'b0;
    @(negedge clk);
    checks++;
    if (!hit || {bus.o_out, bus.o_busy, bus.o_done, bus.o_step} !== 6'b0) begin
      errors++;
      $display("FAIL abort_idle: hit=%b out/busy/done/step=%b, required hit=1 000000",
               hit, {bus.o_out, bus.o_busy, bus.o_done, bus.o_step});
    end
    done_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL abort_no_done: done/busy seen=1 after abort, required 0");
    end
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_start: busy=%b, required 0", bus.o_busy);
    end
    run("after_abort", 1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_busy_write();
    run("busy_write", 1, 1'b1, 1'b0, '0, 1'b0);
    run("busy_write_rerun", 1, 1'b0, 1'b0, '0, 1'b0);
    run("rewrite_start", 1, 1'b0, 1'b1, {1'b1, 4'd2}, 1'b0);
  endtask

`ifdef BLINK_SEQ_REPEAT_EN
  task automatic test_repeat();
    wr(0, {1'b1, 4'd1});
    wr(1, {1'b0, 4'd1});
    wr(2, {1'b1, 4'd0});
    bus.i_repeat = 4'd2;
    run("repeat", 3, 1'b0, 1'b0, '0, 1'b1);
    bus.i_repeat = '0;
  endtask
`endif

  task automatic test_reset_mid_run();
    tcnt = 1;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    for (int it = 1; it <= 4; it++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      tcnt++;
      bus.i_tick = ((tcnt % 4) == 0);
    end
    bus.i_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_high: out=%b before reset, required 1", bus.o_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_out, bus.o_busy, bus.o_done, bus.o_step} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: out/busy/done/step=%b, required 000000",
               {bus.o_out, bus.o_busy, bus.o_done, bus.o_step});
    end
    for (int i = 0; i < STEPS; i++) model_prog[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    run("reset_prog", 1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_program();
    test_wrap();
    test_abort();
    test_busy_write();
`ifdef BLINK_SEQ_REPEAT_EN
    test_repeat();
`endif
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_sequencer.md
# blink_sequencer

Programmable blink-pattern controller for the blinking-machine design. Holds a small program of {level, duration} steps, sequences through them on the 1 Hz tick produced by the clock divider, and drives the LED output through a shared step timer. Replaces the fixed-pattern blinking state machine when software-defined patterns are needed. Start/abort control, busy/done status.

## Interface

Parameters:
- STEPS, 8, number of program steps (power of two, ≥2)
- DUR_W, 4, step duration width in ticks
- REP_W, 4, repeat-count width (used only with BLINK_SEQ_REPEAT_EN)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_tick  in  1  one-cycle time-unit strobe (1 Hz enable from divider)
- i_start  in  1  start program, level-sensitive, sampled in IDLE only
- i_abort  in  1  stop immediately, any state
- i_wr_en  in  1  program write strobe
- i_wr_addr  in  $clog2(STEPS)  step index to write
- i_wr_data  in  DUR_W+1  {level, duration}, level is MSB
- i_repeat  in  REP_W  extra passes, sampled at start (only with BLINK_SEQ_REPEAT_EN)
- o_out  out  1  pattern output
- o_busy  out  1  high in LOAD and RUN
- o_done  out  1  one-cycle pulse at normal completion
- o_step  out  $clog2(STEPS)  current step index

## Operation

- States: IDLE, LOAD, RUN, DONE.
- IDLE: o_out=0, o_step=0. i_start=1 → LOAD with index 0.
- LOAD (1 cycle): read step[index]. If duration=0 → end-of-pass handling. Else timer ← duration, o_out ← level, → RUN.
- RUN: each i_tick decrements timer. Tick with timer=1 → step finished: if index=STEPS-1 → end-of-pass; else index+1, → LOAD.
- End-of-pass: remaining repeats >0 → decrement, index ← 0, → LOAD; else → DONE.
- Duration 0 acts as end-of-program marker. Step 0 with duration 0 → DONE without driving o_out high.
- DONE (1 cycle): o_done=1, o_out=0, → IDLE.
- i_abort: highest priority; from any state → IDLE next cycle, o_out=0, index=0, no o_done. Abort wins over simultaneous start.
- Program writes accepted only while o_busy=0, i.e. in IDLE or DONE; ignored during LOAD/RUN. A write and a start in the same IDLE cycle: write takes effect, start reads the new value.
- Reset: all program entries 0, state IDLE, o_out=0, o_busy=0, o_done=0, o_step=0, timer 0, repeat counter 0.

## Timing

- i_start sampled at edge n → LOAD in cycle n+1 → o_out valid from cycle n+2.
- Step of duration D holds o_out for exactly D i_tick strobes counted from the first tick in RUN. A tick arriving during LOAD is ignored.
- Step-to-step gap: one LOAD cycle, o_out holds the previous level through LOAD.
- o_done asserted exactly one cycle, the cycle after the last step's final tick (or after the LOAD that hits a 0 marker).
- i_start held high in DONE has no effect. Still high in the following IDLE → restart.
- All outputs registered.

## Configuration

- BLINK_SEQ_REPEAT_EN defined: i_repeat port and REP_W-bit repeat counter present. Total passes = i_repeat+1, latched when leaving IDLE.
- Not defined: i_repeat port absent, repeat counter removed, exactly one pass per start.

## Structure

- Shared package blink_pkg: state enum blink_seq_state_t, typedef step_t (packed {level, dur[DUR_W-1:0]}), default parameter constants.
- Sub-module blink_step_timer: loadable down-counter with tick enable and expiry flag (load, tick, expire).
- Program storage is a register array inside blink_sequencer, not a RAM macro.

## Test plan

- Reset mid-RUN (o_out=1): assert i_rst → all outputs 0 asynchronously, program entries read back as 0 (start → immediate o_done, no o_out high).
- Program {1,3},{0,2},{1,1},{x,0}; start → o_out high 3 ticks, low 2, high 1, then o_done pulse; o_step 0,1,2.
- All 8 steps nonzero (alternating level, dur 1) → index wraps to DONE after step 7, no index 8 access.
- Abort during step 1 RUN simultaneous with i_tick → IDLE next cycle, o_out=0, no o_done, timer not decremented.
- Write to step 0 while busy → ignored; after DONE rewrite {1,2} and start → 2-tick high.
- With BLINK_SEQ_REPEAT_EN, i_repeat=2, program {1,1},{0,1},{x,0} → three high/low pairs then one o_done; i_repeat changed mid-run has no effect.
